// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus controller: issues one dbus transaction per load/store and stalls until it completes.
// Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_dbus_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [2:0]            msize,
    input  logic [DATA_W-1:0]     wd,
    input  logic [DATA_W/8-1:0]   strobe,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  misalign_err,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [2:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                state_q;
    logic                  is_write_q;
    logic                  dreq_valid_q;
    logic [ADDR_W-1:0]     dreq_addr_q;
    logic [2:0]            dreq_size_q;
    logic [STRB_W-1:0]     dreq_strobe_q;
    logic [DATA_W-1:0]     dreq_data_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  rdata_valid_q;
    logic                  misalign_err_q;

    logic                  start_s;
    logic                  misalign_s;
    logic                  stall_s;

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] lo);
        logic bad;
        case (size)
            3'd1:    bad = (lo[0] != 1'b0);
            3'd2:    bad = (lo[1:0] != 2'b00);
            3'd3:    bad = (lo[2:0] != 3'b000);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    // Start detection, optional alignment screen and combinational pipeline stall
    always_comb begin
        start_s = mem_valid & (mem_read | mem_write);
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = start_s & is_misaligned(msize, mem_addr[2:0]);
`else
        misalign_s = 1'b0;
`endif
        case (state_q)
            S_IDLE:      stall_s = start_s & ~misalign_s;
            S_WAIT_ADDR: stall_s = 1'b1;
            S_WAIT_DATA: stall_s = 1'b1;
            S_DONE:      stall_s = 1'b0;
            default:     stall_s = 1'b0;
        endcase
    end

    // Access FSM with registered bus request and completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            is_write_q     <= 1'b0;
            dreq_valid_q   <= 1'b0;
            dreq_addr_q    <= {ADDR_W{1'b0}};
            dreq_size_q    <= 3'd0;
            dreq_strobe_q  <= {STRB_W{1'b0}};
            dreq_data_q    <= {DATA_W{1'b0}};
            rdata_q        <= {DATA_W{1'b0}};
            rdata_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            rdata_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_s && misalign_s) begin
                        misalign_err_q <= 1'b1;
                    end else if (start_s) begin
                        // Store wins when both read and write are flagged
                        is_write_q    <= mem_write;
                        dreq_valid_q  <= 1'b1;
                        dreq_addr_q   <= mem_addr;
                        dreq_size_q   <= msize;
                        dreq_strobe_q <= mem_write ? strobe : {STRB_W{1'b0}};
                        dreq_data_q   <= mem_write ? wd : {DATA_W{1'b0}};
                        state_q       <= S_WAIT_ADDR;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_ADDR: begin
                    if (dresp_addr_ok) begin
                        dreq_valid_q <= 1'b0;
                        if (dresp_data_ok) begin
                            if (!is_write_q) begin
                                rdata_q <= dresp_data;
                            end
                            rdata_valid_q <= 1'b1;
                            state_q       <= S_DONE;
                        end else begin
                            state_q <= S_WAIT_DATA;
                        end
                    end else begin
                        state_q <= S_WAIT_ADDR;
                    end
                end
                S_WAIT_DATA: begin
                    if (dresp_data_ok) begin
                        if (!is_write_q) begin
                            rdata_q <= dresp_data;
                        end
                        rdata_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        state_q <= S_WAIT_DATA;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    dreq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall        = stall_s;
    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign misalign_err = misalign_err_q;
    assign dreq_valid   = dreq_valid_q;
    assign dreq_addr    = dreq_addr_q;
    assign dreq_size    = dreq_size_q;
    assign dreq_strobe  = dreq_strobe_q;
    assign dreq_data    = dreq_data_q;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: directed and randomized accesses against a cycle-timeline model.
module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] mem_addr = 64'd0;
    logic [2:0]  msize = 3'd0;
    logic [63:0] wd = 64'd0;
    logic [7:0]  strobe = 8'd0;
    logic        stall;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        misalign_err;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok = 1'b0;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = 64'd0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_rdata = 64'd0;
    logic        dv_prev = 1'b0;
    int          rise_cnt = 0;

    mem_dbus_ctrl dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .msize(msize), .wd(wd),
        .strobe(strobe), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .misalign_err(misalign_err), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    // Counts dreq_valid rising edges as seen at the sampling edge
    always @(negedge clk) begin
        dv_prev <= dreq_valid;
        if (dreq_valid && !dv_prev) rise_cnt <= rise_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = rnd64();
        #1;
        n_checks++;
        if (stall !== 1'b0 || dreq_valid !== 1'b0 || rdata_valid !== 1'b0 || misalign_err !== 1'b0) begin
            n_errors++;
            $display("FAIL idle: stall=%b dreq_valid=%b rdata_valid=%b misalign_err=%b required all 0",
                     stall, dreq_valid, rdata_valid, misalign_err);
        end
    endtask

    // One access: addr_ok a_dly cycles after the first request cycle, data_ok d_dly cycles after addr_ok
    task automatic access(input logic wr, input logic both, input logic [63:0] addr, input logic [2:0] sz,
                          input logic [63:0] wdat, input logic [7:0] strb, input int a_dly,
                          input int d_dly, input logic [63:0] resp);
        int last;
        logic [7:0] e_strb;
        logic [63:0] e_data;
        logic e_stall, e_dv, e_rv;
        last = a_dly + d_dly + 2;
        e_strb = wr ? strb : 8'h00;
        e_data = wr ? wdat : 64'd0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            mem_valid = 1'b1;
            if (c == 0) begin
                mem_write = wr; mem_read = ~wr | both;
                mem_addr = addr; msize = sz; wd = wdat; strobe = strb;
            end else begin
                mem_addr = rnd64(); wd = rnd64(); strobe = 8'($urandom); msize = 3'($urandom_range(0, 3));
            end
            dresp_addr_ok = (c == a_dly + 1);
            dresp_data_ok = (c == a_dly + d_dly + 1);
            dresp_data = dresp_data_ok ? resp : rnd64();
            #1;
            e_stall = (c <= last - 1);
            e_dv = (c >= 1) && (c <= a_dly + 1);
            e_rv = (c == last);
            if (c == last && !wr) exp_rdata = resp;
            n_checks++;
            if (stall !== e_stall) begin
                n_errors++;
                $display("FAIL stall c=%0d: got %b required %b", c, stall, e_stall);
            end
            n_checks++;
            if (dreq_valid !== e_dv) begin
                n_errors++;
                $display("FAIL dreq_valid c=%0d: got %b required %b", c, dreq_valid, e_dv);
            end
            n_checks++;
            if (rdata_valid !== e_rv || misalign_err !== 1'b0) begin
                n_errors++;
                $display("FAIL rdata_valid c=%0d: got %b/%b required %b/0", c, rdata_valid, misalign_err, e_rv);
            end
            if (e_dv) begin
                n_checks++;
                if (dreq_addr !== addr || dreq_size !== sz || dreq_strobe !== e_strb || dreq_data !== e_data) begin
                    n_errors++;
                    $display("FAIL dreq_fields c=%0d: got %h/%0d/%h/%h required %h/%0d/%h/%h", c,
                             dreq_addr, dreq_size, dreq_strobe, dreq_data, addr, sz, e_strb, e_data);
                end
            end
            if (e_rv) begin
                n_checks++;
                if (rdata !== exp_rdata) begin
                    n_errors++;
                    $display("FAIL rdata: got %h required %h", rdata, exp_rdata);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0 || dreq_valid !== 1'b0 || rdata_valid !== 1'b0 || misalign_err !== 1'b0 ||
            rdata !== 64'd0 || dreq_addr !== 64'd0 || dreq_size !== 3'd0 || dreq_strobe !== 8'd0 ||
            dreq_data !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_state: stall=%b dv=%b rv=%b me=%b rdata=%h addr=%h size=%0d strb=%h data=%h required all 0",
                     stall, dreq_valid, rdata_valid, misalign_err, rdata, dreq_addr, dreq_size, dreq_strobe, dreq_data);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 64'd0;
        idle_cycle();
    endtask

    task automatic test_load();
        access(1'b0, 1'b0, 64'h80000008, 3'd3, rnd64(), 8'($urandom), 0, 0, 64'h1122334455667788);
        idle_cycle();
    endtask

    task automatic test_store_hold();
        access(1'b1, 1'b0, 64'h80000003, 3'd0, 64'h00000000_AB000000, 8'h08, 3, 0, rnd64());
        idle_cycle();
    endtask

    task automatic test_split();
        access(1'b0, 1'b0, 64'h80001000, 3'd2, rnd64(), 8'hFF, 0, 3, 64'hCAFEF00D_DEADBEEF);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int base;
        base = rise_cnt;
        access(1'b1, 1'b1, 64'h80002010, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 1, 1, rnd64());
        access(1'b0, 1'b0, 64'h80002018, 3'd3, rnd64(), 8'hFF, 0, 0, 64'h0F0E0D0C0B0A0908);
        idle_cycle();
        @(negedge clk);
        n_checks++;
        if (rise_cnt - base !== 2) begin
            n_errors++;
            $display("FAIL back_to_back_edges: got %0d required 2", rise_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        access(1'b0, 1'b0, 64'h80003000, 3'd3, 64'd0, 8'h00, 0, 0, 64'hA5A5A5A5_5A5A5A5A);
        @(negedge clk);
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 64'h80003008; msize = 3'd3;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        @(negedge clk);
        mem_addr = rnd64();
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || dreq_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_data_state: stall=%b dreq_valid=%b required 1/0", stall, dreq_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_valid = 1'b0; mem_read = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = 64'hFFFF0000FFFF0000;
        exp_rdata = 64'd0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || dreq_valid !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 64'd0 ||
            dreq_addr !== 64'd0 || dreq_data !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_mid: stall=%b dv=%b rv=%b rdata=%h addr=%h data=%h required all 0",
                     stall, dreq_valid, rdata_valid, rdata, dreq_addr, dreq_data);
        end
        repeat (3) idle_cycle();
        n_checks++;
        if (rdata !== 64'd0) begin
            n_errors++;
            $display("FAIL late_data_ok: rdata got %h required 0", rdata);
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 64'h80000002; msize = 3'd2;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL misalign_stall: got %b required 0", stall);
        end
        @(negedge clk);
        mem_valid = 1'b0; mem_read = 1'b0;
        #1;
        n_checks++;
        if (misalign_err !== 1'b1 || dreq_valid !== 1'b0 || rdata_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL misalign_pulse: me=%b dv=%b rv=%b required 1/0/0", misalign_err, dreq_valid, rdata_valid);
        end
        idle_cycle();
`else
        access(1'b0, 1'b0, 64'h80000002, 3'd2, rnd64(), 8'hFF, 0, 1, 64'h7777666655554444);
        idle_cycle();
`endif
    endtask

    task automatic test_random();
        logic [2:0] sz;
        logic [63:0] addr;
        logic wr;
        for (int i = 0; i < 40; i++) begin
            sz = 3'($urandom_range(0, 3));
            addr = rnd64() & ~((64'd1 << sz) - 64'd1);
            wr = 1'($urandom);
            access(wr, 1'($urandom), addr, sz, rnd64(), 8'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), rnd64());
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_hold();
        test_split();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
